// File: rtl/if_fetch_stage_if.sv
// ---------------------------------------------------------------------------
// if_fetch_stage_if
//   Instruction-memory read channel between the fetch stage and the
//   instruction memory. The memory accepts one outstanding read.
//
//   imem_req    : fetch -> mem, one-cycle read request pulse
//   imem_addr   : fetch -> mem, read address (the fetch PC)
//   imem_rvalid : mem -> fetch, read data valid (at least 1 cycle after req)
//   imem_rdata  : mem -> fetch, instruction word
//
//   master : fetch-stage side
//   slave  : memory side
// ---------------------------------------------------------------------------
interface if_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface : if_fetch_stage_if

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage: owns the architectural PC, issues reads to a
//   variable-latency instruction memory (one outstanding read), and loads the
//   IF/ID pipeline register. Handles branch redirects (flushing IF/ID and
//   killing any in-flight read) and pipeline stalls (holding PC and IF/ID,
//   parking an early response in a skid register).
//
//   Parameters
//     RESET_PC  : PC value after reset
//     NOP_INST  : bubble instruction placed in IF/ID
//
//   Ports
//     clk, rst_n     : clock, synchronous active-low reset
//     npc            : next PC from the next-PC logic
//     branch         : redirect to npc, flush IF/ID, kill in-flight read
//     stop           : stall, hold PC and IF/ID
//     pc             : current fetch PC, to the next-PC logic
//     imem           : instruction-memory read channel (master side)
//     id_pc, id_pc4  : PC of the IF/ID instruction and that PC + 4
//     id_inst        : instruction in IF/ID
//     id_valid       : IF/ID holds a real instruction
//     perf_fetch_cnt : deliveries to ID
//     perf_flush_cnt : cycles with branch asserted
//
//   Optional feature macro: IF_PERF_CNT_EN
//     defined   -> two 32-bit wrapping performance counters are built
//     undefined -> both perf outputs are constant 0, no counter flops
// ---------------------------------------------------------------------------
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [31:0]              npc,
    input  logic                     branch,
    input  logic                     stop,
    output logic [31:0]              pc,
    if_fetch_stage_if.master         imem,
    output logic [31:0]              id_pc,
    output logic [31:0]              id_pc4,
    output logic [31:0]              id_inst,
    output logic                     id_valid,
    output logic [31:0]              perf_fetch_cnt,
    output logic [31:0]              perf_flush_cnt
);

    typedef enum logic [1:0] {
        S_REQ,   // issue a read for pc
        S_WAIT,  // read outstanding, response is wanted
        S_DROP,  // read outstanding, response is stale and will be discarded
        S_HOLD   // response parked in the skid register during a stall
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_skid;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_pc4;
    logic [31:0] r_id_inst;
    logic        r_id_valid;

    logic        w_pc_load;
    logic        w_skid_load;
    logic        w_deliver;
    logic [31:0] w_deliver_data;

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_next_state   = r_state;
        w_pc_load      = 1'b0;
        w_skid_load    = 1'b0;
        w_deliver      = 1'b0;
        w_deliver_data = imem.imem_rdata;

        case (r_state)
            S_REQ: begin
                if (branch) w_pc_load    = 1'b1;
                else        w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (branch) begin
                    // A response landing with the branch is simply dropped;
                    // only a still-pending one needs the DROP state.
                    w_pc_load    = 1'b1;
                    w_next_state = imem.imem_rvalid ? S_REQ : S_DROP;
                end else if (imem.imem_rvalid) begin
                    if (!stop) begin
                        w_deliver    = 1'b1;
                        w_pc_load    = 1'b1;
                        w_next_state = S_REQ;
                    end else begin
                        w_skid_load  = 1'b1;
                        w_next_state = S_HOLD;
                    end
                end
            end
            S_DROP: begin
                if (branch)           w_pc_load    = 1'b1;
                if (imem.imem_rvalid) w_next_state = S_REQ;
            end
            S_HOLD: begin
                if (branch) begin
                    w_pc_load    = 1'b1;
                    w_next_state = S_REQ;
                end else if (!stop) begin
                    w_deliver      = 1'b1;
                    w_deliver_data = r_skid;
                    w_pc_load      = 1'b1;
                    w_next_state   = S_REQ;
                end
            end
            default: w_next_state = S_REQ;
        endcase
    end

    // Request is a decode of the registered state; rst_n gating keeps it low
    // while reset is held even though the state already reads REQ.
    assign imem.imem_req  = rst_n && (r_state == S_REQ) && !branch;
    assign imem.imem_addr = r_pc;
    assign pc             = r_pc;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        // NOTE: the skid register is reset too, so its contents are defined
        // even though they are only ever read after being loaded.
        if (!rst_n) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_skid     <= '0;
            r_id_pc    <= 32'h0000_0000;
            r_id_pc4   <= 32'h0000_0004;
            r_id_inst  <= NOP_INST;
            r_id_valid <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_pc_load)   r_pc   <= npc;
            if (w_skid_load) r_skid <= imem.imem_rdata;

            // IF/ID priority: flush, then stall hold, then load, then bubble.
            if (branch) begin
                r_id_inst  <= NOP_INST;
                r_id_valid <= 1'b0;
                r_id_pc    <= npc;
                r_id_pc4   <= npc + 32'd4;
            end else if (stop) begin
                r_id_inst  <= r_id_inst;
                r_id_valid <= r_id_valid;
            end else if (w_deliver) begin
                r_id_inst  <= w_deliver_data;
                r_id_valid <= 1'b1;
                r_id_pc    <= r_pc;
                r_id_pc4   <= r_pc + 32'd4;
            end else begin
                r_id_inst  <= NOP_INST;
                r_id_valid <= 1'b0;
            end
        end
    end

    assign id_pc    = r_id_pc;
    assign id_pc4   = r_id_pc4;
    assign id_inst  = r_id_inst;
    assign id_valid = r_id_valid;

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_deliver) r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (branch)    r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign perf_fetch_cnt = r_fetch_cnt;
    assign perf_flush_cnt = r_flush_cnt;
`else
    assign perf_fetch_cnt = 32'h0000_0000;
    assign perf_flush_cnt = 32'h0000_0000;
`endif

endmodule : if_fetch_stage
